// File: rtl/ws2811_pkg.sv
// Shared types and helpers for the WS2811 frame sequencer.
package ws2811_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ARM,
      ACK,
      WAIT,
      DRAIN,
      LATCH
   } seq_state_t;

   localparam int RGB_W = 24;

   // Strip latch gap expressed in clock cycles.
   function automatic int latch_cycles(input int clock_speed, input int us);
      return (clock_speed / 1_000_000) * us;
   endfunction

endpackage

// File: rtl/ws2811_offset_tracker.sv
// Per-frame animation offset: steps +1 / -1 or holds on each accepted frame
// tick, wrapping naturally at the power-of-two pattern length.
module ws2811_offset_tracker #(
   parameter int OFF_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             advance,
   input  logic             pause,
   input  logic             direction,
   output logic [OFF_W-1:0] offset
);

   // Offset register; the modulo wrap comes from the fixed register width.
   always_ff @(posedge clk) begin
      if (rst) begin
         offset <= '0;
      end else if (advance && !pause) begin
         if (direction) offset <= offset + 1'b1;
         else           offset <= offset - 1'b1;
      end
   end

endmodule

// File: rtl/ws2811_frame_sequencer.sv
// One WS2811 strip refresh per frame tick: walks the pixels, addresses the
// pattern ROM (offset-animated), hands each ROM word to the transmitter under
// its start/busy handshake, then holds the strip low for the latch gap.
module ws2811_frame_sequencer
   import ws2811_pkg::*;
#(
   parameter int CLOCK_SPEED           = 50_000_000,
   parameter int UNITS_NUMBER          = 100,
   parameter int PATTERN_COLORS_NUMBER = 128,
   parameter int ROM_LATENCY           = 1,
   parameter int LATCH_US              = 60
) (
   input  logic                                     clkIN,
   input  logic                                     resetIN,
   input  logic                                     frameTickIN,
   input  logic                                     pauseIN,
   input  logic                                     directionIN,
   output logic [$clog2(PATTERN_COLORS_NUMBER)-1:0] addrOUT,
   input  logic [RGB_W-1:0]                         romDataIN,
   output logic                                     txStartOUT,
   output logic [RGB_W-1:0]                         txDataOUT,
   input  logic                                     txBusyIN,
   output logic                                     frameActiveOUT,
   output logic                                     frameDoneOUT,
   output logic                                     overrunOUT
);

   localparam int ADDR_W       = $clog2(PATTERN_COLORS_NUMBER);
   localparam int UNIT_W       = $clog2(UNITS_NUMBER + 1);
   localparam int LATCH_CYCLES = latch_cycles(CLOCK_SPEED, LATCH_US);
   // The DRAIN load edge and the registered done pulse each cost one cycle,
   // so the counter starts two short to put frameDoneOUT exactly LATCH_CYCLES
   // after the final busy fall.
   localparam int LATCH_LOAD   = (LATCH_CYCLES > 2) ? LATCH_CYCLES - 2 : 0;
   localparam int LAT_W        = (LATCH_LOAD > 0) ? $clog2(LATCH_LOAD + 1) : 1;

   localparam logic [UNIT_W-1:0] LAST_UNIT = UNIT_W'(UNITS_NUMBER - 1);
   localparam logic [2:0]        ROM_WAIT  = 3'(ROM_LATENCY);
   localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(LATCH_LOAD);

   seq_state_t        state_q, state_d;
   logic [UNIT_W-1:0] unit_q;
   logic [2:0]        rom_cnt_q;
   logic [LAT_W-1:0]  latch_cnt_q;
   logic [ADDR_W-1:0] offset;

   logic accept, capture, start_d, unit_inc, latch_load, finish, overrun_d;

   ws2811_offset_tracker #(.OFF_W(ADDR_W)) u_offset (
      .clk       (clkIN),
      .rst       (resetIN),
      .advance   (accept),
      .pause     (pauseIN),
      .direction (directionIN),
      .offset    (offset)
   );

   // Unit and offset are both registered, so the address is stable for the
   // whole FETCH window; the add truncates to the ROM index width.
   assign addrOUT = offset + ADDR_W'(unit_q);

   // State register.
   always_ff @(posedge clkIN) begin
      if (resetIN) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic and single-cycle control strobes.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      capture    = 1'b0;
      start_d    = 1'b0;
      unit_inc   = 1'b0;
      latch_load = 1'b0;
      finish     = 1'b0;
      overrun_d  = frameTickIN && (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (frameTickIN) begin
               accept  = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (rom_cnt_q == ROM_WAIT) begin
               capture = 1'b1;
               state_d = ARM;
            end
         end
         ARM: begin
            if (!txBusyIN) begin
               start_d = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            if (txBusyIN) begin
               if (unit_q == LAST_UNIT) begin
                  state_d = DRAIN;
               end else begin
                  unit_inc = 1'b1;
                  state_d  = WAIT;
               end
            end
         end
         WAIT: begin
            if (!txBusyIN) state_d = FETCH;
         end
         DRAIN: begin
            if (!txBusyIN) begin
               latch_load = 1'b1;
               state_d    = LATCH;
            end
         end
         LATCH: begin
            if (latch_cnt_q == '0) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Counters, transmit word and registered output pulses.
   always_ff @(posedge clkIN) begin
      if (resetIN) begin
         unit_q         <= '0;
         rom_cnt_q      <= '0;
         latch_cnt_q    <= '0;
         txDataOUT      <= '0;
         txStartOUT     <= 1'b0;
         frameDoneOUT   <= 1'b0;
         overrunOUT     <= 1'b0;
         frameActiveOUT <= 1'b0;
      end else begin
         if (accept)        unit_q <= '0;
         else if (unit_inc) unit_q <= unit_q + 1'b1;

         // Counts cycles since the address was presented; restarts on every
         // entry into FETCH because it is held at zero everywhere else.
         if (state_q != FETCH) rom_cnt_q <= '0;
         else if (!capture)    rom_cnt_q <= rom_cnt_q + 1'b1;

         if (capture) txDataOUT <= romDataIN;

         if (latch_load)
            latch_cnt_q <= LAT_INIT;
         else if (state_q == LATCH && latch_cnt_q != '0)
            latch_cnt_q <= latch_cnt_q - 1'b1;

         txStartOUT   <= start_d;
         frameDoneOUT <= finish;
         overrunOUT   <= overrun_d;

         if (accept)      frameActiveOUT <= 1'b1;
         else if (finish) frameActiveOUT <= 1'b0;
      end
   end

endmodule
